mul_div_unit: RTL and testbench

Iterative 32-bit multiply/divide execution unit between the register bank read ports and its write port. Takes two operands (from rd1/rd2) plus a destination index, runs a shift-add multiply or restoring divide over 32 cycles, then presents result, destination index and a one-cycle write strobe that drive wd3/wa3/we3 directly. The decoder holds new multi-cycle issues off while `busy` is high.

---
 rtl/mul_div_unit.sv | 97 +++++++++
 tb/tb_mul_div_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative 32-bit unsigned MUL/UMULH/UDIV/UREM feeding the register-bank write port.
// Latency: 33 cycles from accept to done (1 for divide-by-zero); busy holds off new issues.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       wa_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       wa_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc, acc_nxt;
  logic [31:0] opa, opb;
  logic [1:0]  op_q;
  logic [3:0]  wa_q;
  logic        accept, div0;
  logic [32:0] msum, rem_sh;
  logic [31:0] rem_sub;
  logic        ge;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    accept    = (state == IDLE) && start && !flush;
    div0      = op[1] && (b == 32'd0);
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = div0 ? DONE : RUN;
      RUN:     if (cnt == 5'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Multiply shifts the multiplier (opb) right; divide shifts the dividend (opa) left.
  always_comb begin
    msum    = {1'b0, acc[63:32]} + {1'b0, (opb[0] ? opa : 32'd0)};
    rem_sh  = {acc[63:32], opa[31]};
    ge      = (rem_sh >= {1'b0, opb});
    rem_sub = rem_sh[31:0] - opb;
    acc_nxt = {msum, acc[31:1]};
    if (op_q[1]) acc_nxt = {(ge ? rem_sub : rem_sh[31:0]), acc[30:0], ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opa    <= 32'd0;
      opb    <= 32'd0;
      op_q   <= 2'd0;
      wa_q   <= 4'd0;
      result <= '0;
      wa_out <= 4'd0;
    end else if (accept) begin
      op_q <= op;
      wa_q <= wa_in;
      opa  <= a;
      opb  <= b;
      cnt  <= 5'd31;
      acc  <= 64'd0;
      if (div0) begin
        result <= op[0] ? a : '1;
        wa_out <= wa_in;
      end
    end else if (state == RUN && !flush) begin
      acc <= acc_nxt;
      if (cnt != 5'd0) cnt <= cnt - 5'd1;
      if (op_q[1]) opa <= {opa[30:0], 1'b0};
      else         opb <= {1'b0, opb[31:1]};
      if (cnt == 5'd0) begin
        result <= op_q[0] ? acc_nxt[63:32] : acc_nxt[31:0];
        wa_out <= wa_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, ignored starts, flush and reset abort.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [3:0]  wa_in;
  logic        busy, done;
  logic [31:0] result;
  logic [3:0]  wa_out;
  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wa_in(wa_in), .flush(flush), .busy(busy), .done(done),
    .result(result), .wa_out(wa_out)
  );

  always #5 clk = ~clk;

  // lat = edges after the accept edge until done is seen (-1 on timeout)
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] w, output int lat);
    int n;
    n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    op = o; a = x; b = y; wa_in = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    lat = (done === 1'b1) ? n : -1;
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (wa_out !== 4'd0) begin errors++; $display("FAIL reset_wa: got %h want 0", wa_out); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int lat;
    do_op(2'b00, 32'd7, 32'd6, 4'd3, lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL mul_latency: got %0d want 32", lat); end
    checks++; if (result !== 32'd42) begin errors++; $display("FAIL mul_result: got %h want 2a", result); end
    checks++; if (wa_out !== 4'd3) begin errors++; $display("FAIL mul_wa: got %h want 3", wa_out); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_width: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_mul_wide;
    int lat;
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, lat);
    checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL umulh_max: got %h want fffffffe", result); end
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, lat);
    checks++; if (result !== 32'h0000_0001) begin errors++; $display("FAIL mul_max: got %h want 00000001", result); end
  endtask

  task automatic test_div;
    int lat;
    do_op(2'b10, 32'd100, 32'd7, 4'd6, lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL udiv_latency: got %0d want 32", lat); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL udiv_result: got %h want e", result); end
    checks++; if (wa_out !== 4'd6) begin errors++; $display("FAIL udiv_wa: got %h want 6", wa_out); end
    do_op(2'b11, 32'd100, 32'd7, 4'd1, lat);
    checks++; if (result !== 32'd2) begin errors++; $display("FAIL urem_result: got %h want 2", result); end
    checks++; if (wa_out !== 4'd1) begin errors++; $display("FAIL urem_wa: got %h want 1", wa_out); end
    do_op(2'b10, 32'h8000_0000, 32'd1, 4'd2, lat);
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL udiv_msb: got %h want 80000000", result); end
  endtask

  task automatic test_div_zero;
    int lat;
    do_op(2'b10, 32'd5, 32'd0, 4'd7, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL div0_latency: got %0d want 0", lat); end
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_quot: got %h want ffffffff", result); end
    checks++; if (wa_out !== 4'd7) begin errors++; $display("FAIL div0_wa: got %h want 7", wa_out); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL div0_after: got done=%b busy=%b want 0 0", done, busy); end
    do_op(2'b11, 32'd5, 32'd0, 4'd8, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL rem0_latency: got %0d want 0", lat); end
    checks++; if (result !== 32'd5) begin errors++; $display("FAIL rem0_result: got %h want 5", result); end
  endtask

  task automatic test_start_ignored;
    int n;
    @(posedge clk); #1;
    op = 2'b00; a = 32'd7; b = 32'd6; wa_in = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    repeat (10) begin @(posedge clk); #1; n++; end
    op = 2'b10; a = 32'd1000; b = 32'd3; wa_in = 4'd9; start = 1'b1;
    @(posedge clk); #1; n++;
    start = 1'b0;
    while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 32) begin errors++; $display("FAIL ign_run_latency: got %0d want 32", n); end
    checks++; if (result !== 32'd42) begin errors++; $display("FAIL ign_run_result: got %h want 2a", result); end
    checks++; if (wa_out !== 4'd3) begin errors++; $display("FAIL ign_run_wa: got %h want 3", wa_out); end
    op = 2'b00; a = 32'd2; b = 32'd3; wa_in = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_done_busy: got %b want 0", busy); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (result !== 32'd42) begin errors++; $display("FAIL ign_done_result: got %h want 2a", result); end
  endtask

  task automatic test_flush;
    int lat, seen;
    do_op(2'b00, 32'd3, 32'd5, 4'd4, lat);
    checks++; if (result !== 32'd15) begin errors++; $display("FAIL flush_setup: got %h want f", result); end
    @(posedge clk); #1;
    op = 2'b10; a = 32'd1000; b = 32'd3; wa_in = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
    checks++; if (result !== 32'd15) begin errors++; $display("FAIL flush_result: got %h want f", result); end
    checks++; if (wa_out !== 4'd4) begin errors++; $display("FAIL flush_wa: got %h want 4", wa_out); end
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d done cycles want 0", seen); end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    op = 2'b10; a = 32'd1000; b = 32'd3; wa_in = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_mid_result: got %h want 0", result); end
    checks++; if (wa_out !== 4'd0) begin errors++; $display("FAIL rst_mid_wa: got %h want 0", wa_out); end
    @(posedge clk); #1;
    rst = 1'b1;
    do_op(2'b00, 32'd9, 32'd9, 4'd2, lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL post_rst_latency: got %0d want 32", lat); end
    checks++; if (result !== 32'd81 || wa_out !== 4'd2) begin errors++; $display("FAIL post_rst_result: got %h/%h want 51/2", result, wa_out); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    op = 2'b00; a = 32'd0; b = 32'd0; wa_in = 4'd0;
    #3;
    test_reset;
    test_mul;
    test_mul_wide;
    test_div;
    test_div_zero;
    test_start_ignored;
    test_flush;
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
